counter_status_reader: RTL and testbench

//  Processor-side consumer of the counter peripherals: samples DN/CU/CD/ACC of up to
//  NUM_CNT counter instances every clk, detects DN rising edges into sticky pending

---
 rtl/counter_status_reader_pkg.sv | 22 ++
 rtl/counter_status_reader_if.sv | 18 +
 rtl/counter_status_reader_edge.sv | 46 ++++
 rtl/counter_status_reader.sv | 118 +++++++++++
 tb/tb_counter_status_reader.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/counter_status_reader_pkg.sv
// Shared types and constants for the counter status reader: read FSM states,
// status word layout and the default ACC width of the counter bank.
package counter_status_reader_pkg;

  localparam int ACC_W_DEF = 8;
  localparam int STAT_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAPT = 2'd1,
    ST_ACK  = 2'd2,
    ST_WAIT = 2'd3
  } rd_state_t;

  // Status word as seen by the CPU: {err, pend, cd, cu, dn}.
  function automatic logic [STAT_W-1:0] pack_status(input logic err, input logic pend,
                                                   input logic cd, input logic cu,
                                                   input logic dn);
    return {err, pend, cd, cu, dn};
  endfunction

endpackage

// File: rtl/counter_status_reader_if.sv
// CPU-side read handshake bus of the counter status reader.
interface counter_status_reader_if #(
  parameter int SEL_W = 2,
  parameter int ACC_W = 8
);
  import counter_status_reader_pkg::*;

  logic              rd_req;
  logic [SEL_W-1:0]  rd_sel;
  logic              rd_clr;
  logic              rd_ack;
  logic [ACC_W-1:0]  rd_data;
  logic [STAT_W-1:0] rd_status;

  modport master (output rd_req, rd_sel, rd_clr, input rd_ack, rd_data, rd_status);
  modport slave  (input rd_req, rd_sel, rd_clr, output rd_ack, rd_data, rd_status);

endinterface

// File: rtl/counter_status_reader_edge.sv
// One counter channel: registered snapshot of DN/CU/CD/ACC plus a sticky
// pending flag set on a DN rising edge; a simultaneous set beats the clear.
module counter_status_reader_edge #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cnt_dn,
  input  logic             cnt_cu,
  input  logic             cnt_cd,
  input  logic [ACC_W-1:0] cnt_acc,
  input  logic             clr,
  output logic             snap_dn,
  output logic             snap_cu,
  output logic             snap_cd,
  output logic [ACC_W-1:0] snap_acc,
  output logic             pending
);

  logic prev_dn;
  logic rise;

  assign rise = snap_dn & ~prev_dn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      snap_dn  <= 1'b0;
      snap_cu  <= 1'b0;
      snap_cd  <= 1'b0;
      snap_acc <= '0;
      prev_dn  <= 1'b0;
      pending  <= 1'b0;
    end else begin
      snap_dn  <= cnt_dn;
      snap_cu  <= cnt_cu;
      snap_cd  <= cnt_cd;
      snap_acc <= cnt_acc;
      prev_dn  <= snap_dn;
      if (rise)
        pending <= 1'b1;
      else if (clr)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/counter_status_reader.sv
// Samples the counter bank, turns DN rises into sticky pending flags and an
// irq, and serves CPU snapshot/status reads over a req/ack handshake.
module counter_status_reader
  import counter_status_reader_pkg::*;
#(
  parameter int NUM_CNT = 4,
  parameter int ACC_W   = ACC_W_DEF,
  parameter int SEL_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CNT-1:0]       cnt_dn,
  input  logic [NUM_CNT-1:0]       cnt_cu,
  input  logic [NUM_CNT-1:0]       cnt_cd,
  input  logic [NUM_CNT*ACC_W-1:0] cnt_acc,
  input  logic [NUM_CNT-1:0]       irq_en,
  counter_status_reader_if.slave   bus,
  output logic                     irq
);

  rd_state_t         state;
  logic [SEL_W-1:0]  sel_q;
  logic              clr_q;
  logic              sel_valid;

  logic [NUM_CNT-1:0] snap_dn;
  logic [NUM_CNT-1:0] snap_cu;
  logic [NUM_CNT-1:0] snap_cd;
  logic [NUM_CNT-1:0] pending;
  logic [NUM_CNT-1:0] clr_vec;
  logic [ACC_W-1:0]   snap_acc [NUM_CNT];

  logic [ACC_W-1:0]   mux_data;
  logic [STAT_W-1:0]  mux_stat;

  for (genvar i = 0; i < NUM_CNT; i++) begin : g_ch
    counter_status_reader_edge #(.ACC_W(ACC_W)) u_edge (
      .clk      (clk),
      .reset    (reset),
      .cnt_dn   (cnt_dn[i]),
      .cnt_cu   (cnt_cu[i]),
      .cnt_cd   (cnt_cd[i]),
      .cnt_acc  (cnt_acc[i*ACC_W +: ACC_W]),
      .clr      (clr_vec[i]),
      .snap_dn  (snap_dn[i]),
      .snap_cu  (snap_cu[i]),
      .snap_cd  (snap_cd[i]),
      .snap_acc (snap_acc[i]),
      .pending  (pending[i])
    );
  end

  assign sel_valid = (int'(sel_q) < NUM_CNT);

  // Loop-based decode keeps an over-wide sel_q from aliasing onto a real channel.
  always_comb begin
    clr_vec  = '0;
    mux_data = '0;
    mux_stat = pack_status(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NUM_CNT; i++) begin
      if (int'(sel_q) == i) begin
        clr_vec[i] = (state == ST_CAPT) && clr_q;
        mux_data   = snap_acc[i];
        mux_stat   = pack_status(1'b0, pending[i], snap_cd[i], snap_cu[i], snap_dn[i]);
      end
    end
    if (!sel_valid) begin
      clr_vec = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      sel_q         <= '0;
      clr_q         <= 1'b0;
      bus.rd_ack    <= 1'b0;
      bus.rd_data   <= '0;
      bus.rd_status <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.rd_req) begin
            sel_q <= bus.rd_sel;
            clr_q <= bus.rd_clr;
            state <= ST_CAPT;
          end
        end
        ST_CAPT: begin
          bus.rd_data   <= mux_data;
          bus.rd_status <= mux_stat;
          bus.rd_ack    <= 1'b1;
          state         <= ST_ACK;
        end
        ST_ACK: begin
          bus.rd_ack <= 1'b0;
          state      <= bus.rd_req ? ST_WAIT : ST_IDLE;
        end
        ST_WAIT: begin
          if (!bus.rd_req)
            state <= ST_IDLE;
        end
        default: begin
          bus.rd_ack <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      irq <= 1'b0;
    else
      irq <= |(pending & irq_en);
  end

endmodule

// File: tb/tb_counter_status_reader.sv
// Directed bench for counter_status_reader: expected read responses are queued
// at request time and checked by an independent monitor on each rd_ack.
module tb_counter_status_reader;

  logic        clk;
  logic        rst_n;
  logic [3:0]  cnt_dn;
  logic [3:0]  cnt_cu;
  logic [3:0]  cnt_cd;
  logic [31:0] cnt_acc;
  logic [3:0]  irq_en;
  logic        irq;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  logic [12:0] exp_q [$];

  counter_status_reader_if #(.SEL_W(3), .ACC_W(8)) bus ();

  counter_status_reader #(.NUM_CNT(4), .ACC_W(8), .SEL_W(3)) dut (
    .clk     (clk),
    .reset   (rst_n),
    .cnt_dn  (cnt_dn),
    .cnt_cu  (cnt_cu),
    .cnt_cd  (cnt_cd),
    .cnt_acc (cnt_acc),
    .irq_en  (irq_en),
    .bus     (bus),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.rd_ack) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ack_unexpected actual=1 required=0");
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        check("rd_data", 32'(bus.rd_data), 32'(e[12:5]));
        check("rd_status", 32'(bus.rd_status), 32'(e[4:0]));
      end
    end
  end

  task automatic do_read(input logic [2:0] sel, input logic clr, input logic [7:0] ed,
                         input logic [4:0] es, input logic dn0_rise);
    int n;
    @(negedge clk);
    if (dn0_rise) cnt_dn[0] = 1'b1;
    bus.rd_sel = sel;
    bus.rd_clr = clr;
    bus.rd_req = 1'b1;
    exp_q.push_back({ed, es});
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.rd_ack && n < 10);
    check("read_latency", 32'(n), 32'd2);
    @(negedge clk);
    bus.rd_req = 1'b0;
    bus.rd_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks_before;
    clk        = 1'b0;
    rst_n      = 1'b0;
    cnt_dn     = 4'b0000;
    cnt_cu     = 4'b1010;
    cnt_cd     = 4'b0101;
    cnt_acc    = {8'hC3, 8'h55, 8'h3C, 8'hA1};
    irq_en     = 4'b0000;
    bus.rd_req = 1'b0;
    bus.rd_sel = '0;
    bus.rd_clr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", 32'(bus.rd_ack), 32'd0);
    check("reset_data", 32'(bus.rd_data), 32'd0);
    check("reset_status", 32'(bus.rd_status), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ch2 rise with only ch2 enabled: irq three edges later
    @(negedge clk);
    cnt_dn[2] = 1'b1;
    irq_en    = 4'b0100;
    @(posedge clk); #1; check("irq_t1", 32'(irq), 32'd0);
    @(posedge clk); #1; check("irq_t2", 32'(irq), 32'd0);
    @(posedge clk); #1; check("irq_t3", 32'(irq), 32'd1);
    do_read(3'd2, 1'b0, 8'h55, 5'b01101, 1'b0);

    // ch1 read-clear drops irq one edge after the capture
    @(negedge clk);
    irq_en    = 4'b0010;
    cnt_dn[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("irq_ch1_set", 32'(irq), 32'd1);
    do_read(3'd1, 1'b1, 8'h3C, 5'b01011, 1'b0);
    check("irq_before_clr", 32'(irq), 32'd1);
    @(posedge clk); #1;
    check("irq_after_clr", 32'(irq), 32'd0);
    do_read(3'd1, 1'b0, 8'h3C, 5'b00011, 1'b0);

    // ch0: rise coincides with read-clear, set must win
    @(negedge clk);
    cnt_dn[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cnt_dn[0] = 1'b0;
    repeat (2) @(posedge clk);
    do_read(3'd0, 1'b1, 8'hA1, 5'b01101, 1'b1);
    do_read(3'd0, 1'b0, 8'hA1, 5'b01101, 1'b0);
    do_read(3'd0, 1'b1, 8'hA1, 5'b01101, 1'b0);
    do_read(3'd0, 1'b0, 8'hA1, 5'b00101, 1'b0);

    // last valid channel and an out-of-range select
    do_read(3'd3, 1'b0, 8'hC3, 5'b00010, 1'b0);
    do_read(3'd5, 1'b1, 8'h00, 5'b10000, 1'b0);

    // request held for 10 clocks: exactly one ack
    @(negedge clk);
    bus.rd_sel = 3'd2;
    bus.rd_clr = 1'b0;
    bus.rd_req = 1'b1;
    exp_q.push_back({8'h55, 5'b01101});
    acks_before = ack_cnt;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("held_req_acks", 32'(ack_cnt - acks_before), 32'd1);
    bus.rd_req = 1'b0;
    do_read(3'd2, 1'b1, 8'h55, 5'b01101, 1'b0);
    do_read(3'd2, 1'b0, 8'h55, 5'b00101, 1'b0);

    // all four pending, then reset in the middle of a read
    @(negedge clk);
    cnt_dn = 4'b0000;
    irq_en = 4'b1111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cnt_dn = 4'b1111;
    repeat (4) @(posedge clk);
    #1;
    check("irq_all", 32'(irq), 32'd1);
    do_read(3'd3, 1'b0, 8'hC3, 5'b01011, 1'b0);
    @(negedge clk);
    bus.rd_sel = 3'd1;
    bus.rd_req = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrd_ack", 32'(bus.rd_ack), 32'd0);
    check("midrd_data", 32'(bus.rd_data), 32'd0);
    check("midrd_status", 32'(bus.rd_status), 32'd0);
    check("midrd_irq", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check("ack_in_reset", 32'(bus.rd_ack), 32'd0);
    @(negedge clk);
    bus.rd_req = 1'b0;
    rst_n      = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
